// File: rtl/img_proc_pkg.sv
// Shared constants and types for the RGB888-to-gray stream block.
// Luma weights, pipeline latency and the geometry checker state type.
package img_proc_pkg;

  localparam logic [7:0]  LUMA_R     = 8'd77;
  localparam logic [7:0]  LUMA_G     = 8'd150;
  localparam logic [7:0]  LUMA_B     = 8'd29;
  localparam logic [16:0] LUMA_RND   = 17'd128;
  localparam int          LUMA_SHIFT = 8;
  localparam int          PIPE_LAT   = 3;

  typedef enum logic [1:0] {
    GS_WAIT_LOW,
    GS_ARMED,
    GS_IN_FRAME
  } geom_state_t;

  function automatic logic [15:0] mul8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return {8'd0, a} * {8'd0, b};
  endfunction

endpackage

// File: rtl/gray_geom_checker.sv
// Frame geometry checker: counts pixels per line and lines per frame
// against the expected image size and raises sticky mismatch flags.
module gray_geom_checker
  import img_proc_pkg::*;
#(
  parameter int C_IMG_WIDTH  = 640,
  parameter int C_IMG_HEIGHT = 480
) (
  input  logic clk_in1,
  input  logic rst_n,
  input  logic vsync,
  input  logic href_g,
  output logic geom_err_width,
  output logic geom_err_height,
  output logic frame_done
);

  localparam int PW = $clog2(C_IMG_WIDTH + 1) + 1;
  localparam int LW = $clog2(C_IMG_HEIGHT + 1) + 1;

  geom_state_t   state, state_nxt;
  logic          vs_q;
  logic          hg_q;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic [PW-1:0] pix_inc;
  logic [LW-1:0] line_inc;
  logic [LW-1:0] line_end;
  logic          vs_rise;
  logic          vs_fall;
  logic          line_close;

  assign vs_rise    = vsync & ~vs_q;
  assign vs_fall    = ~vsync & vs_q;
  assign line_close = hg_q & ~href_g;

  // Saturating increments keep an overlong line flagged.
  assign pix_inc  = (pix_cnt == '1) ? pix_cnt : pix_cnt + 1'b1;
  assign line_inc = (line_cnt == '1) ? line_cnt : line_cnt + 1'b1;

  // A line closing in the same cycle as vsync falls counts first.
  assign line_end = line_close ? line_inc : line_cnt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      GS_WAIT_LOW: if (!vsync)  state_nxt = GS_ARMED;
      GS_ARMED:    if (vs_rise) state_nxt = GS_IN_FRAME;
      GS_IN_FRAME: if (vs_fall) state_nxt = GS_ARMED;
      default:                  state_nxt = GS_WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      state           <= GS_WAIT_LOW;
      vs_q            <= 1'b0;
      hg_q            <= 1'b0;
      pix_cnt         <= '0;
      line_cnt        <= '0;
      geom_err_width  <= 1'b0;
      geom_err_height <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_q       <= vsync;
      hg_q       <= href_g;
      frame_done <= 1'b0;
      unique case (state)
        GS_ARMED: begin
          if (vs_rise) begin
            geom_err_width  <= 1'b0;
            geom_err_height <= 1'b0;
            line_cnt        <= '0;
            pix_cnt         <= href_g ? PW'(1) : '0;
          end
        end
        GS_IN_FRAME: begin
          if (line_close) begin
            if (pix_cnt != PW'(C_IMG_WIDTH))
              geom_err_width <= 1'b1;
            pix_cnt  <= '0;
            line_cnt <= line_inc;
          end else if (href_g) begin
            pix_cnt <= pix_inc;
          end
          if (vs_fall) begin
            geom_err_height <= (line_end != LW'(C_IMG_HEIGHT));
            frame_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rgb888_to_gray_stream.sv
// Pipelined RGB888 to 8-bit luma stream, 3-cycle latency, vsync/href framed.
// Optional frame geometry checker built when RGB2GRAY_GEOM_CHECK_EN is defined.
module rgb888_to_gray_stream
  import img_proc_pkg::*;
#(
  parameter int C_IMG_WIDTH  = 640,
  parameter int C_IMG_HEIGHT = 480
) (
  input  logic       clk_in1,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic [7:0] post_img_gray,
  output logic       geom_err_width,
  output logic       geom_err_height,
  output logic       frame_done
);

  logic                href_g;
  logic [15:0]         prod_r;
  logic [15:0]         prod_g;
  logic [15:0]         prod_b;
  logic [16:0]         sum_q;
  logic [7:0]          gray_q;
  logic [PIPE_LAT-1:0] vs_sr;
  logic [PIPE_LAT-1:0] hg_sr;

  assign href_g = per_img_href & per_img_vsync;

  // Zeroed products make the gray output 0 whenever href is low.
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      prod_r <= '0;
      prod_g <= '0;
      prod_b <= '0;
      sum_q  <= '0;
      gray_q <= '0;
      vs_sr  <= '0;
      hg_sr  <= '0;
    end else begin
      prod_r <= href_g ? mul8(LUMA_R, per_img_red)   : '0;
      prod_g <= href_g ? mul8(LUMA_G, per_img_green) : '0;
      prod_b <= href_g ? mul8(LUMA_B, per_img_blue)  : '0;
      sum_q  <= {1'b0, prod_r} + {1'b0, prod_g}
              + {1'b0, prod_b} + LUMA_RND;
      gray_q <= sum_q[LUMA_SHIFT +: 8];
      vs_sr  <= {vs_sr[PIPE_LAT-2:0], per_img_vsync};
      hg_sr  <= {hg_sr[PIPE_LAT-2:0], href_g};
    end
  end

  assign post_img_vsync = vs_sr[PIPE_LAT-1];
  assign post_img_href  = hg_sr[PIPE_LAT-1];
  assign post_img_gray  = gray_q;

`ifdef RGB2GRAY_GEOM_CHECK_EN
  gray_geom_checker #(
    .C_IMG_WIDTH  (C_IMG_WIDTH),
    .C_IMG_HEIGHT (C_IMG_HEIGHT)
  ) u_geom (
    .clk_in1         (clk_in1),
    .rst_n           (rst_n),
    .vsync           (per_img_vsync),
    .href_g          (href_g),
    .geom_err_width  (geom_err_width),
    .geom_err_height (geom_err_height),
    .frame_done      (frame_done)
  );
`else
  assign geom_err_width  = 1'b0;
  assign geom_err_height = 1'b0;
  assign frame_done      = 1'b0;
`endif

endmodule

// File: tb/tb_rgb888_to_gray_stream.sv
// Directed bench for rgb888_to_gray_stream on a reduced 16x8 image.
// Geometry expectations follow RGB2GRAY_GEOM_CHECK_EN.
module tb_rgb888_to_gray_stream;

  localparam int W = 16;
  localparam int H = 8;
`ifdef RGB2GRAY_GEOM_CHECK_EN
  localparam logic GEOM = 1'b1;
`else
  localparam logic GEOM = 1'b0;
`endif

  logic       clk_in1 = 1'b0;
  logic       rst_n   = 1'b0;
  logic       vs      = 1'b0;
  logic       hr      = 1'b0;
  logic [7:0] r       = '0;
  logic [7:0] g       = '0;
  logic [7:0] b       = '0;
  logic       post_img_vsync;
  logic       post_img_href;
  logic [7:0] post_img_gray;
  logic       geom_err_width;
  logic       geom_err_height;
  logic       frame_done;

  rgb888_to_gray_stream #(
    .C_IMG_WIDTH  (W),
    .C_IMG_HEIGHT (H)
  ) dut (
    .clk_in1         (clk_in1),
    .rst_n           (rst_n),
    .per_img_vsync   (vs),
    .per_img_href    (hr),
    .per_img_red     (r),
    .per_img_green   (g),
    .per_img_blue    (b),
    .post_img_vsync  (post_img_vsync),
    .post_img_href   (post_img_href),
    .post_img_gray   (post_img_gray),
    .geom_err_width  (geom_err_width),
    .geom_err_height (geom_err_height),
    .frame_done      (frame_done)
  );

  always #5 clk_in1 = ~clk_in1;

  int checks    = 0;
  int errors    = 0;
  int align_err = 0;
  int out_pix   = 0;
  int fd_cnt    = 0;
  int fd_base   = 0;
  logic [9:0] hist [3];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] luma(input logic [7:0] rr,
                                      input logic [7:0] gg,
                                      input logic [7:0] bb);
    logic [31:0] s;
    s = 77 * rr + 150 * gg + 29 * bb + 128;
    return s[15:8];
  endfunction

  // One clock; delayed-stream model tracks vsync/href/gray 3 cycles back.
  task automatic step();
    logic [9:0] cur;
    logic       hg;
    logic       rs;
    hg  = hr & vs;
    rs  = rst_n;
    cur = {vs, hg, hg ? luma(r, g, b) : 8'h00};
    @(posedge clk_in1);
    if (!rs) begin
      hist[0] = '0;
      hist[1] = '0;
      hist[2] = '0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = cur;
    end
    #1;
    if ({post_img_vsync, post_img_href, post_img_gray} !== hist[2])
      align_err++;
    if (post_img_href) out_pix++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic pix(input string tag, input logic [7:0] rr,
                     input logic [7:0] gg, input logic [7:0] bb,
                     input logic [7:0] exp);
    hr = 1'b1; r = rr; g = gg; b = bb;
    step();
    hr = 1'b0;
    step();
    step();
    chk({tag, "_href"}, post_img_href, 1);
    chk(tag, post_img_gray, exp);
    step();
    chk({tag, "_gate"}, post_img_gray, 0);
  endtask

  task automatic line(input int n, input int gap);
    for (int p = 0; p < n; p++) begin
      hr = 1'b1;
      r  = 8'(p * 7 + 3);
      g  = 8'(p * 13);
      b  = 8'(255 - p);
      step();
    end
    hr = 1'b0;
    repeat (gap) step();
  endtask

  task automatic frame(input int lines, input int bad_line,
                       input int bad_len, input bit same_edge);
    int n;
    vs = 1'b1;
    step();
    step();
    for (int l = 0; l < lines; l++) begin
      n = (l == bad_line) ? bad_len : W;
      if (l == bad_line) chk("werr_pre", geom_err_width, 0);
      line(n, (same_edge && l == lines - 1) ? 0 : 5);
      if (l == bad_line) chk("werr_line", geom_err_width, GEOM);
    end
    hr = 1'b0;
    vs = 1'b0;
    step();
  endtask

  initial begin
    repeat (3) step();
    chk("rst_vs", post_img_vsync, 0);
    chk("rst_href", post_img_href, 0);
    chk("rst_gray", post_img_gray, 0);
    chk("rst_werr", geom_err_width, 0);
    chk("rst_herr", geom_err_height, 0);
    chk("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    repeat (3) step();

    vs = 1'b1;
    step();
    pix("white", 8'd255, 8'd255, 8'd255, 8'hFF);
    pix("black", 8'd0, 8'd0, 8'd0, 8'h00);
    pix("red", 8'd255, 8'd0, 8'd0, 8'h4D);
    pix("green", 8'd0, 8'd255, 8'd0, 8'h95);
    pix("blue", 8'd0, 8'd0, 8'd255, 8'h1D);
    pix("mix", 8'd100, 8'd50, 8'd200, 8'h52);
    vs = 1'b0;
    repeat (5) step();

    out_pix = 0;
    fd_base = fd_cnt;
    frame(H, -1, 0, 1'b0);
    chk("clean_fd", frame_done, GEOM);
    chk("clean_werr", geom_err_width, 0);
    chk("clean_herr", geom_err_height, 0);
    repeat (4) step();
    chk("clean_pix", out_pix, W * H);
    chk("clean_fdcnt", fd_cnt - fd_base, GEOM);

    frame(H, 3, W - 1, 1'b0);
    chk("short_fd", frame_done, GEOM);
    chk("short_werr", geom_err_width, GEOM);
    chk("short_herr", geom_err_height, 0);
    repeat (4) step();
    chk("short_hold", geom_err_width, GEOM);
    vs = 1'b1;
    step();
    chk("werr_clr", geom_err_width, 0);

    frame(H - 1, -1, 0, 1'b0);
    chk("h7_fd", frame_done, GEOM);
    chk("h7_herr", geom_err_height, GEOM);
    chk("h7_werr", geom_err_width, 0);
    repeat (4) step();

    frame(H, -1, 0, 1'b1);
    chk("same_fd", frame_done, GEOM);
    chk("same_herr", geom_err_height, 0);
    chk("same_werr", geom_err_width, 0);
    repeat (4) step();

    out_pix = 0;
    fd_base = fd_cnt;
    vs = 1'b0;
    repeat (3) begin
      hr = 1'b1; r = 8'd200; g = 8'd100; b = 8'd50;
      step();
      step();
      hr = 1'b0;
      step();
    end
    repeat (4) step();
    chk("novs_pix", out_pix, 0);
    chk("novs_fd", fd_cnt - fd_base, 0);
    chk("novs_herr", geom_err_height, 0);

    fd_base = fd_cnt;
    vs = 1'b1;
    step();
    line(W, 5);
    line(W, 5);
    hr = 1'b1;
    rst_n = 1'b0;
    step();
    chk("mrst_vs", post_img_vsync, 0);
    chk("mrst_href", post_img_href, 0);
    chk("mrst_gray", post_img_gray, 0);
    step();
    rst_n = 1'b1;
    hr = 1'b0;
    repeat (3) line(W, 5);
    vs = 1'b0;
    step();
    repeat (4) step();
    chk("mrst_fd", fd_cnt - fd_base, 0);
    chk("mrst_herr", geom_err_height, 0);
    chk("mrst_werr", geom_err_width, 0);

    out_pix = 0;
    fd_base = fd_cnt;
    frame(H, -1, 0, 1'b0);
    chk("post_fd", frame_done, GEOM);
    chk("post_herr", geom_err_height, 0);
    chk("post_werr", geom_err_width, 0);
    repeat (4) step();
    chk("post_pix", out_pix, W * H);

    chk("align", align_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb888_to_gray_stream.md
# rgb888_to_gray_stream

Pipelined RGB888-to-luma converter placed directly upstream of the bilinear interpolation scaler in the clk_in1 (pixel) domain. Accepts a vsync/href-framed RGB888 stream from the sensor/source and emits a vsync/href-framed 8-bit gray stream with matched control timing. The scaler's per_img_vsync, per_img_href and per_img_gray inputs connect directly to this block's outputs. Includes an optional frame-geometry checker that flags line/frame size mismatches before the scaler sees them.

## Interface
- C_IMG_WIDTH, 640, expected active pixels per line
- C_IMG_HEIGHT, 480, expected active lines per frame
- clk_in1  in  1  pixel clock
- rst_n  in  1  reset, synchronous, active-low; clock clk_in1
- per_img_vsync  in  1  frame valid, high for whole frame
- per_img_href  in  1  pixel valid, high during active pixels
- per_img_red  in  8  R component
- per_img_green  in  8  G component
- per_img_blue  in  8  B component
- post_img_vsync  out  1  vsync delayed 3 cycles
- post_img_href  out  1  gated href delayed 3 cycles
- post_img_gray  out  8  luma
- geom_err_width  out  1  sticky: a line in current/last frame ≠ C_IMG_WIDTH (macro only, else tied 0)
- geom_err_height  out  1  sticky: line count ≠ C_IMG_HEIGHT (macro only, else tied 0)
- frame_done  out  1  one-cycle pulse at vsync falling edge of a checked frame (macro only, else tied 0)

## Operation
- Luma: Y = (77·R + 150·G + 29·B + 128) >> 8. Stage 1 registers three 16-bit products; stage 2 registers 17-bit sum incl. +128; stage 3 registers bits [15:8]. Max sum 65408, no saturation needed.
- Gating: href_g = per_img_href & per_img_vsync; href outside vsync is dropped (output href 0, gray 0).
- Stage-1 products forced to 0 when href_g = 0, so post_img_gray = 0 whenever post_img_href = 0.
- vsync and href_g carried through 3-stage shift registers aligned with data.
- Checker FSM (macro on): WAIT_LOW → (vsync=0) ARMED → (vsync rising) IN_FRAME → (vsync falling) ARMED. After reset starts in WAIT_LOW so a frame already in progress at reset release is never checked.
- IN_FRAME: pixel counter increments on href_g; on href_g falling compares to C_IMG_WIDTH, sets geom_err_width on mismatch, clears pixel counter, increments line counter. On vsync falling, line counter compared to C_IMG_HEIGHT; frame_done pulses.
- Error flags cleared on vsync rising (entering IN_FRAME), held through and after frame end until next frame starts.
- Counters width $clog2(dim+1)+1, saturate at all-ones (overlong line still flagged).
- href falling and vsync falling in same cycle: line closed and counted first, then height compared.

## Timing
- Reset values: all outputs 0, pipelines 0, counters 0, FSM WAIT_LOW.
- Latency 3 clk_in1 cycles input→output for vsync, href, gray; throughput 1 pixel/cycle, no backpressure.
- frame_done and flag updates observed 1 cycle after the input vsync/href falling edge (not pipeline-aligned).
- Reset mid-frame: outputs drop to 0 next cycle; remainder of that frame passes through pipeline but is unchecked.

## Configuration
- RGB2GRAY_GEOM_CHECK_EN defined: checker FSM, counters and flags built.
- Undefined: checker absent; geom_err_width, geom_err_height, frame_done tied 0; datapath identical.

## Structure
- Shared package img_proc_pkg: luma coefficient constants (77, 150, 29, rounding 128), shift 8, pipeline latency constant 3.
- One sub-module gray_geom_checker holding FSM and counters, instantiated under the macro.

## Test plan
- Single pixel R=255,G=255,B=255 → gray 0xFF 3 cycles later; R=G=B=0 → 0x00; R=255 only → 0x4D; G=255 only → 0x95.
- Full 640×480 frame, 5-cycle line gaps → 307200 output pixels, vsync/href edges exactly 3 cycles delayed, no errors, one frame_done.
- Frame with line 10 of 639 pixels → geom_err_width=1 after that line, stays high until next vsync rising.
- Frame of 479 lines → geom_err_height=1 with frame_done pulse.
- href pulses while vsync=0 → post_img_href stays 0, gray 0, counters unchanged.
- rst_n low for 2 cycles mid-frame → outputs 0, remainder unchecked (no flags), next full frame checked clean.
